// File: rtl/width_pack_conv.sv
// width_pack_conv: narrow-to-wide packer. Collects RATIO beats of IN_W bits into one
// IN_W*RATIO-bit word with valid/ready on both sides. in_last flushes a partial word.
// out_keep marks the lanes that hold real data.
// Optional build macro WIDTH_PACK_STAT_EN adds the stat_partial_cnt output, which counts
// partial words handed downstream.
module width_pack_conv #(
   parameter int unsigned IN_W      = 8,
   parameter int unsigned RATIO     = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       in_data,
   input  logic                  in_vld,
   input  logic                  in_last,
   output logic                  in_rdy,
   output logic [IN_W*RATIO-1:0] out_data,
   output logic [RATIO-1:0]      out_keep,
   output logic                  out_last,
   output logic                  out_vld,
   input  logic                  out_rdy
`ifdef WIDTH_PACK_STAT_EN
   ,
   output logic [15:0]           stat_partial_cnt
`endif
);

   localparam int unsigned OUT_W = IN_W * RATIO;
   localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [OUT_W-1:0] acc_q, acc_d, acc_beat;
   logic [RATIO-1:0] keep_q, keep_d, keep_beat;
   logic [CNT_W-1:0] cnt_q, cnt_d, lane;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [RATIO-1:0] out_keep_q, out_keep_d;
   logic             out_last_q, out_last_d;
   logic             out_vld_q, out_vld_d;
   logic             accept, complete, drain;

   // Handshake decode; in_rdy depends only on the output stage and out_rdy.
   always_comb begin
      in_rdy   = !out_vld_q || out_rdy;
      accept   = in_vld && in_rdy;
      complete = accept && ((cnt_q == CNT_W'(RATIO - 1)) || in_last);
      drain    = out_vld_q && out_rdy;
   end

   // Accumulator and keep as they would look with the incoming beat merged in.
   always_comb begin
      lane      = MSB_FIRST ? (CNT_W'(RATIO - 1) - cnt_q) : cnt_q;
      acc_beat  = acc_q;
      keep_beat = keep_q;
      for (int i = 0; i < int'(RATIO); i++) begin
         if (lane == CNT_W'(i)) begin
            acc_beat[i*IN_W +: IN_W] = in_data;
            keep_beat[i]             = 1'b1;
         end
      end
   end

   // Next-state: a completing beat loads the output stage and clears the accumulator;
   // a drain without a new word drops out_vld.
   always_comb begin
      acc_d      = acc_q;
      keep_d     = keep_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_keep_d = out_keep_q;
      out_last_d = out_last_q;
      out_vld_d  = out_vld_q;
      if (complete) begin
         out_data_d = acc_beat;
         out_keep_d = keep_beat;
         out_last_d = in_last;
         out_vld_d  = 1'b1;
         acc_d      = '0;
         keep_d     = '0;
         cnt_d      = '0;
      end else begin
         if (accept) begin
            acc_d  = acc_beat;
            keep_d = keep_beat;
            cnt_d  = cnt_q + CNT_W'(1);
         end
         if (drain) begin
            out_vld_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         keep_q     <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_keep_q <= '0;
         out_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         keep_q     <= keep_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_keep_q <= out_keep_d;
         out_last_q <= out_last_d;
         out_vld_q  <= out_vld_d;
      end
   end

   // Drive outputs directly from the output stage registers.
   always_comb begin
      out_data = out_data_q;
      out_keep = out_keep_q;
      out_last = out_last_q;
      out_vld  = out_vld_q;
   end

`ifdef WIDTH_PACK_STAT_EN
   logic [15:0] stat_q, stat_d;

   // Count handed-off words that are missing at least one lane, saturating.
   always_comb begin
      stat_d = stat_q;
      if (drain && !(&out_keep_q) && (stat_q != 16'hFFFF)) begin
         stat_d = stat_q + 16'd1;
      end
   end

   // Statistics register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   // Expose the counter.
   always_comb begin
      stat_partial_cnt = stat_q;
   end
`endif

endmodule

// File: tb/tb_width_pack_conv.sv
// Bench for width_pack_conv: three instances (8x2 MSB-first, 8x2 LSB-first, 8x4 MSB-first)
// share clk/rst. Expected words go into per-instance queues; a monitor pops and compares
// on every output handshake.
module tb_width_pack_conv;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din   [3];
   logic        vld   [3];
   logic        last  [3];
   logic        ordy  [3];
   logic        irdy  [3];
   logic        ovld  [3];
   logic        olast [3];
   logic [31:0] odata [3];
   logic [3:0]  okeep [3];

   logic [15:0] od_a, od_b;
   logic [31:0] od_c;
   logic [1:0]  ok_a, ok_b;
   logic [3:0]  ok_c;
   logic [15:0] stat_c;

   int checks   = 0;
   int failures = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   always #5 clk = ~clk;

   assign odata[0] = {16'h0, od_a};
   assign odata[1] = {16'h0, od_b};
   assign odata[2] = od_c;
   assign okeep[0] = {2'b0, ok_a};
   assign okeep[1] = {2'b0, ok_b};
   assign okeep[2] = ok_c;

`ifdef WIDTH_PACK_STAT_EN
   logic [15:0] stat_a, stat_b;
`else
   assign stat_c = 16'h0;
`endif

   width_pack_conv #(.IN_W(8), .RATIO(2), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst), .in_data(din[0]), .in_vld(vld[0]), .in_last(last[0]),
      .in_rdy(irdy[0]), .out_data(od_a), .out_keep(ok_a), .out_last(olast[0]),
      .out_vld(ovld[0]), .out_rdy(ordy[0])
`ifdef WIDTH_PACK_STAT_EN
      , .stat_partial_cnt(stat_a)
`endif
   );

   width_pack_conv #(.IN_W(8), .RATIO(2), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .in_data(din[1]), .in_vld(vld[1]), .in_last(last[1]),
      .in_rdy(irdy[1]), .out_data(od_b), .out_keep(ok_b), .out_last(olast[1]),
      .out_vld(ovld[1]), .out_rdy(ordy[1])
`ifdef WIDTH_PACK_STAT_EN
      , .stat_partial_cnt(stat_b)
`endif
   );

   width_pack_conv #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst), .in_data(din[2]), .in_vld(vld[2]), .in_last(last[2]),
      .in_rdy(irdy[2]), .out_data(od_c), .out_keep(ok_c), .out_last(olast[2]),
      .out_vld(ovld[2]), .out_rdy(ordy[2])
`ifdef WIDTH_PACK_STAT_EN
      , .stat_partial_cnt(stat_c)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [31:0] data, input logic [3:0] keep,
                       input logic l);
      exp_t e;
      e.data = data;
      e.keep = keep;
      e.last = l;
      case (d)
         0: qa.push_back(e);
         1: qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   task automatic check_pop(input int d);
      exp_t e;
      bit   got = 1'b0;
      case (d)
         0: if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
         1: if (qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
         default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL unexpected_word dut%0d: got data %h keep %b, expected none",
                  d, odata[d], okeep[d]);
      end else begin
         chk($sformatf("word_data dut%0d", d), odata[d], e.data);
         chk($sformatf("word_keep dut%0d", d), {28'h0, okeep[d]}, {28'h0, e.keep});
         chk($sformatf("word_last dut%0d", d), {31'h0, olast[d]}, {31'h0, e.last});
      end
   endtask

   // Pops one expected word per output handshake seen just before the next rising edge.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int d = 0; d < 3; d++) begin
               if (ovld[d] && ordy[d]) check_pop(d);
            end
         end
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Call just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input int d, input logic [7:0] b, input logic l);
      int n = 0;
      din[d]  = b;
      vld[d]  = 1'b1;
      last[d] = l;
      @(negedge clk);
      while (!irdy[d] && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk($sformatf("accept_timeout dut%0d", d), 32'h0, 32'h1);
      @(posedge clk);
      #1;
      vld[d]  = 1'b0;
      last[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         din[d]  = 8'h00;
         vld[d]  = 1'b0;
         last[d] = 1'b0;
         ordy[d] = 1'b1;
      end
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_vld dut%0d", d), {31'h0, ovld[d]}, 32'h0);
         chk($sformatf("rst_data dut%0d", d), odata[d], 32'h0);
         chk($sformatf("rst_keep dut%0d", d), {28'h0, okeep[d]}, 32'h0);
      end
      align();
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk($sformatf("rdy_after_rst dut%0d", d), {31'h0, irdy[d]}, 32'h1);
      align();

      // MSB-first pair, single-cycle valid pulse
      push(0, 32'h1234, 4'b0011, 1'b0);
      send(0, 8'h12, 1'b0);
      send(0, 8'h34, 1'b0);
      @(negedge clk);
      chk("vld_first_cycle", {31'h0, ovld[0]}, 32'h1);
      @(negedge clk);
      chk("vld_one_cycle", {31'h0, ovld[0]}, 32'h0);
      align();

      // LSB-first pair
      push(1, 32'h3412, 4'b0011, 1'b0);
      send(1, 8'h12, 1'b0);
      send(1, 8'h34, 1'b0);
      repeat (2) align();

      // Ratio 4 partial flush, then the next beat starts in the top lane
      push(2, 32'hAABBCC00, 4'b1110, 1'b1);
      push(2, 32'hDD000000, 4'b1000, 1'b1);
      send(2, 8'hAA, 1'b0);
      send(2, 8'hBB, 1'b0);
      send(2, 8'hCC, 1'b1);
      send(2, 8'hDD, 1'b1);
      repeat (2) align();

      // Backpressure: hold 0x1234, then drain with 0x56/0x78 waiting
      ordy[0] = 1'b0;
      push(0, 32'h1234, 4'b0011, 1'b0);
      push(0, 32'h5678, 4'b0011, 1'b0);
      send(0, 8'h12, 1'b0);
      send(0, 8'h34, 1'b0);
      fork
         begin
            send(0, 8'h56, 1'b0);
            send(0, 8'h78, 1'b0);
         end
         begin
            repeat (5) begin
               @(negedge clk);
               chk("hold_rdy", {31'h0, irdy[0]}, 32'h0);
               chk("hold_data", odata[0], 32'h1234);
               chk("hold_vld", {31'h0, ovld[0]}, 32'h1);
            end
            align();
            ordy[0] = 1'b1;
         end
      join
      repeat (2) align();

      // Completion on the same edge as the drain keeps out_vld high
      push(0, 32'h0102, 4'b0011, 1'b0);
      push(0, 32'h0300, 4'b0010, 1'b1);
      send(0, 8'h01, 1'b0);
      send(0, 8'h02, 1'b0);
      fork
         send(0, 8'h03, 1'b1);
         begin
            @(negedge clk);
            chk("cont_vld_a", {31'h0, ovld[0]}, 32'h1);
            @(negedge clk);
            chk("cont_vld_b", {31'h0, ovld[0]}, 32'h1);
            chk("cont_data_b", odata[0], 32'h0300);
         end
      join
      repeat (2) align();

      // Reset mid-word discards the accumulated beat
      send(0, 8'h11, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("vld_in_rst", {31'h0, ovld[0]}, 32'h0);
      align();
      rst = 1'b0;
      push(0, 32'h2233, 4'b0011, 1'b0);
      send(0, 8'h22, 1'b0);
      send(0, 8'h33, 1'b0);
      repeat (2) align();

      // Packets of 2, 4 and 1 beats on the ratio-4 instance
      push(2, 32'h11220000, 4'b1100, 1'b1);
      push(2, 32'h31323334, 4'b1111, 1'b1);
      push(2, 32'h41000000, 4'b1000, 1'b1);
      send(2, 8'h11, 1'b0);
      send(2, 8'h22, 1'b1);
      send(2, 8'h31, 1'b0);
      send(2, 8'h32, 1'b0);
      send(2, 8'h33, 1'b0);
      send(2, 8'h34, 1'b1);
      send(2, 8'h41, 1'b1);
      repeat (3) align();
`ifdef WIDTH_PACK_STAT_EN
      @(negedge clk);
      chk("stat_after_packets", {16'h0, stat_c}, 32'd2);
      align();
      rst = 1'b1;
      align();
      rst = 1'b0;
      @(negedge clk);
      chk("stat_after_rst", {16'h0, stat_c}, 32'd0);
`else
      @(negedge clk);
      chk("stat_absent", {16'h0, stat_c}, 32'd0);
`endif
      repeat (2) align();

      chk("queue_a_empty", qa.size(), 32'd0);
      chk("queue_b_empty", qb.size(), 32'd0);
      chk("queue_c_empty", qc.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
